seg_scan4: RTL and testbench

//  Multiplexed 4-digit 7-segment scanner for the board debug display, clocked from clk_1m.

---
 rtl/seg_scan4.sv | 155 +++++++++++++++
 tb/tb_seg_scan4.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan4.sv
// seg_scan4 - multiplexed 4-digit 7-segment scanner for the board debug display.
//
// Ports:
//   clk_1m    in   1   scan clock (1 MHz)
//   rst_n     in   1   asynchronous active-low reset
//   number    in   16  hex value; [15:12] -> digit 3 (sel[3]), [3:0] -> digit 0 (sel[0])
//   dot       in   4   decimal point per digit
//   load      in   1   asynchronous capture request; synchronised rising edge forces capture
//   freeze    in   1   1: suppress frame-boundary capture
//   blank_lz  in   1   1: blank leading zero digits (dp still shown)
//   sel       out  4   digit enables, polarity per SEL_ACTIVE_LOW
//   seg       out  8   {dp, g..a}, polarity per SEG_ACTIVE_LOW
//   frame     out  1   one-cycle pulse at the start of each digit-0 slot
//
// Each digit slot lasts SCAN_DIV cycles; the first BLANK_CYC cycles drive
// everything off to stop ghosting between digits. number/dot are sampled into a
// shadow at each frame boundary (unless frozen) or on a forced load, so a frame
// never mixes two values except when a forced load lands mid-frame.

module seg_scan4 #(
    parameter int unsigned SCAN_DIV       = 250,
    parameter int unsigned BLANK_CYC      = 16,
    parameter bit          SEL_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk_1m,
    input  logic        rst_n,
    input  logic [15:0] number,
    input  logic [3:0]  dot,
    input  logic        load,
    input  logic        freeze,
    input  logic        blank_lz,
    output logic [3:0]  sel,
    output logic [7:0]  seg,
    output logic        frame
);

    if (SCAN_DIV < 2 || BLANK_CYC >= SCAN_DIV) begin : g_bad_param
        $error("seg_scan4: SCAN_DIV must be >= 2 and BLANK_CYC < SCAN_DIV");
    end

    localparam int unsigned    PW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]  LP_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]  LP_BLANK = PW'(BLANK_CYC);
    localparam logic [3:0]     SEL_OFF  = SEL_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [7:0]     SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    typedef enum logic {
        ST_BLANK,
        ST_ON
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_pre;
    logic [1:0]    r_idx;
    logic [15:0]   r_num_sh;
    logic [3:0]    r_dot_sh;
    logic          r_ld_s1;
    logic          r_ld_s2;
    logic          r_ld_s3;

    logic          w_pre_wrap;
    logic [PW-1:0] w_pre_nxt;
    logic [1:0]    w_idx_nxt;
    logic          w_frame_wrap;
    state_t        w_st_nxt;
    logic          w_ld_rise;
    logic          w_capture;
    logic [3:0]    w_nib;
    logic [3:0]    w_lz;
    logic [6:0]    w_seg7;
    logic [7:0]    w_seg_on;
    logic [3:0]    w_sel_on;

    function automatic logic [6:0] f_hex7(input logic [3:0] n);
        case (n)
            4'h0: f_hex7 = 7'h3F;
            4'h1: f_hex7 = 7'h06;
            4'h2: f_hex7 = 7'h5B;
            4'h3: f_hex7 = 7'h4F;
            4'h4: f_hex7 = 7'h66;
            4'h5: f_hex7 = 7'h6D;
            4'h6: f_hex7 = 7'h7D;
            4'h7: f_hex7 = 7'h07;
            4'h8: f_hex7 = 7'h7F;
            4'h9: f_hex7 = 7'h6F;
            4'hA: f_hex7 = 7'h77;
            4'hB: f_hex7 = 7'h7C;
            4'hC: f_hex7 = 7'h39;
            4'hD: f_hex7 = 7'h5E;
            4'hE: f_hex7 = 7'h79;
            default: f_hex7 = 7'h71;
        endcase
    endfunction

    always_comb begin
        w_pre_wrap   = (r_pre == LP_LAST);
        w_pre_nxt    = w_pre_wrap ? '0 : r_pre + 1'b1;
        w_idx_nxt    = w_pre_wrap ? r_idx + 2'd1 : r_idx;
        w_frame_wrap = w_pre_wrap && (r_idx == 2'd3);
        // State tracks the prescaler value it is registered alongside.
        w_st_nxt     = (w_pre_nxt >= LP_BLANK) ? ST_ON : ST_BLANK;
        w_ld_rise    = r_ld_s2 & ~r_ld_s3;
        w_capture    = (w_frame_wrap & ~freeze) | w_ld_rise;

        w_nib        = r_num_sh[{r_idx, 2'b00} +: 4];
        // w_lz[i]: shadow nibbles i..3 are all zero.
        w_lz[3]      = (r_num_sh[15:12] == 4'h0);
        w_lz[2]      = w_lz[3] && (r_num_sh[11:8] == 4'h0);
        w_lz[1]      = w_lz[2] && (r_num_sh[7:4] == 4'h0);
        w_lz[0]      = 1'b0;
        w_seg7       = (blank_lz && w_lz[r_idx]) ? 7'h00 : f_hex7(w_nib);
        w_seg_on     = {r_dot_sh[r_idx], w_seg7};
        w_sel_on     = 4'b0001 << r_idx;
    end

    always_ff @(posedge clk_1m or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_BLANK;
            r_pre    <= '0;
            r_idx    <= '0;
            r_num_sh <= '0;
            r_dot_sh <= '0;
            r_ld_s1  <= 1'b0;
            r_ld_s2  <= 1'b0;
            r_ld_s3  <= 1'b0;
            sel      <= SEL_OFF;
            seg      <= SEG_OFF;
            frame    <= 1'b0;
        end else begin
            r_pre   <= w_pre_nxt;
            r_idx   <= w_idx_nxt;
            r_state <= w_st_nxt;
            r_ld_s1 <= load;
            r_ld_s2 <= r_ld_s1;
            r_ld_s3 <= r_ld_s2;
            frame   <= w_frame_wrap;
            if (w_capture) begin
                r_num_sh <= number;
                r_dot_sh <= dot;
            end
            case (r_state)
                ST_ON: begin
                    sel <= SEL_ACTIVE_LOW ? ~w_sel_on : w_sel_on;
                    seg <= SEG_ACTIVE_LOW ? ~w_seg_on : w_seg_on;
                end
                default: begin
                    sel <= SEL_OFF;
                    seg <= SEG_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan4.sv
module tb_seg_scan4;

    localparam int SD   = 10;
    localparam int BC   = 2;
    localparam int FRM  = 4 * SD;

    logic        clk_1m = 1'b0;
    logic        rst_n  = 1'b0;
    logic [15:0] number = '0;
    logic [3:0]  dot    = '0;
    logic        load   = 1'b0;
    logic        freeze = 1'b0;
    logic        blank_lz = 1'b0;

    logic [3:0]  sel_l, sel_h;
    logic [7:0]  seg_l, seg_h;
    logic        frame_l, frame_h;

    always #5 clk_1m = ~clk_1m;

    seg_scan4 #(.SCAN_DIV(SD), .BLANK_CYC(BC), .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) u_dut_lo (
        .clk_1m(clk_1m), .rst_n(rst_n), .number(number), .dot(dot), .load(load),
        .freeze(freeze), .blank_lz(blank_lz), .sel(sel_l), .seg(seg_l), .frame(frame_l));

    seg_scan4 #(.SCAN_DIV(SD), .BLANK_CYC(BC), .SEL_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk_1m(clk_1m), .rst_n(rst_n), .number(number), .dot(dot), .load(load),
        .freeze(freeze), .blank_lz(blank_lz), .sel(sel_h), .seg(seg_h), .frame(frame_h));

    localparam logic [25:0] RST_VEC = {4'hF, 8'hFF, 1'b0, 4'h0, 8'h00, 1'b0};

    logic [25:0] act;
    assign act = {sel_l, seg_l, frame_l, sel_h, seg_h, frame_h};

    int total = 0;
    int bad   = 0;

    // Reference model: edges since reset release, shadow value, load history.
    int          kk = 0;
    logic [15:0] sh_num = '0;
    logic [3:0]  sh_dot = '0;
    bit          lh [int];
    logic [25:0] exp_vec = RST_VEC;
    bit          exp_on  = 1'b0;
    int          exp_idx = 0;
    logic [6:0]  hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic bit lget(int j);
        return (j >= 1 && lh.exists(j)) ? lh[j] : 1'b0;
    endfunction

    // Advance one clock edge and compute what both DUTs must show after it.
    task automatic tick();
        logic [15:0] hi;
        logic [3:0]  s;
        logic [7:0]  g;
        bit          fr;
        bit          cap;
        @(posedge clk_1m);
        if (!rst_n) begin
            kk = 0; sh_num = '0; sh_dot = '0; lh.delete();
            exp_vec = RST_VEC; exp_on = 1'b0; exp_idx = 0;
        end else begin
            exp_idx = (kk / SD) % 4;
            exp_on  = (kk % SD) >= BC;
            hi = sh_num >> (4 * exp_idx);
            s  = exp_on ? (4'b0001 << exp_idx) : 4'b0000;
            g  = '0;
            if (exp_on) begin
                g[7]   = sh_dot[exp_idx];
                g[6:0] = (blank_lz && exp_idx != 0 && hi == 16'h0) ? 7'h00 : hex_tbl[hi[3:0]];
            end
            kk = kk + 1;
            fr  = (kk % FRM) == 0;
            cap = (fr && !freeze) || (lget(kk - 2) && !lget(kk - 3));
            lh[kk] = load;
            if (cap) begin
                sh_num = number;
                sh_dot = dot;
            end
            exp_vec = {~s, ~g, fr, s, g, fr};
        end
        @(negedge clk_1m);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) begin
            number = 16'($urandom); dot = 4'($urandom); load = 1'($urandom);
            freeze = 1'($urandom); blank_lz = 1'($urandom);
            tick();
            total++;
            if (act !== RST_VEC) begin
                bad++; $display("FAIL reset_hold act=%h req=%h", act, RST_VEC);
            end
        end
        number = 16'h0; dot = 4'h0; load = 1'b0; freeze = 1'b0; blank_lz = 1'b0;
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++;
            if (act !== exp_vec) begin
                bad++; $display("FAIL release_model act=%h req=%h", act, exp_vec);
            end
            total++;
            if (sel_l !== ((i == 3) ? 4'b1110 : 4'b1111)) begin
                bad++; $display("FAIL release_sel cyc=%0d act=%b req=%b", i, sel_l,
                                (i == 3) ? 4'b1110 : 4'b1111);
            end
        end
    endtask

    task automatic test_digits();
        logic [7:0] want [4] = '{~8'h71, ~8'h77, ~8'hDB, ~8'h06};
        int on_cnt = 0;
        int fr_cnt = 0;
        number = 16'h12AF; dot = 4'b0100; blank_lz = 1'b0; freeze = 1'b0;
        do begin
            tick(); total++;
            if (act !== exp_vec) begin bad++; $display("FAIL digits_sync act=%h req=%h", act, exp_vec); end
        end while (kk % FRM != 0);
        repeat (FRM) begin
            tick(); total++;
            if (act !== exp_vec) begin bad++; $display("FAIL digits_model act=%h req=%h", act, exp_vec); end
            if (sel_l != 4'hF) on_cnt++;
            if (frame_l) fr_cnt++;
            if (exp_on) begin
                total++;
                if ({sel_l, seg_l} !== {~(4'b0001 << exp_idx), want[exp_idx]}) begin
                    bad++; $display("FAIL digits_const idx=%0d act=%b/%h req=%b/%h", exp_idx,
                                    sel_l, seg_l, ~(4'b0001 << exp_idx), want[exp_idx]);
                end
            end
        end
        total++;
        if (on_cnt != 4 * (SD - BC)) begin bad++; $display("FAIL digits_on_cycles act=%0d req=%0d", on_cnt, 4 * (SD - BC)); end
        total++;
        if (fr_cnt != 1) begin bad++; $display("FAIL digits_frame_count act=%0d req=1", fr_cnt); end
    endtask

    task automatic test_lz();
        logic [7:0] want_a [4] = '{~8'h3F, ~8'h4F, 8'hFF, 8'hFF};
        logic [7:0] want_b [4] = '{~8'h3F, 8'hFF, 8'hFF, 8'hFF};
        number = 16'h0030; dot = 4'h0; blank_lz = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) number = 16'h0000;
            do begin
                tick(); total++;
                if (act !== exp_vec) begin bad++; $display("FAIL lz_sync act=%h req=%h", act, exp_vec); end
            end while (kk % FRM != 0);
            repeat (FRM) begin
                tick(); total++;
                if (act !== exp_vec) begin bad++; $display("FAIL lz_model act=%h req=%h", act, exp_vec); end
                if (exp_on) begin
                    total++;
                    if (seg_l !== (pass == 0 ? want_a[exp_idx] : want_b[exp_idx])) begin
                        bad++; $display("FAIL lz_const pass=%0d idx=%0d act=%h req=%h", pass, exp_idx, seg_l,
                                        pass == 0 ? want_a[exp_idx] : want_b[exp_idx]);
                    end
                end
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_freeze();
        number = 16'h1111; dot = 4'h0; freeze = 1'b0;
        do begin
            tick(); total++;
            if (act !== exp_vec) begin bad++; $display("FAIL freeze_sync act=%h req=%h", act, exp_vec); end
        end while (kk % FRM != 0);
        freeze = 1'b1; number = 16'h2222;
        repeat (3 * FRM) begin
            tick(); total++;
            if (act !== exp_vec) begin bad++; $display("FAIL freeze_model act=%h req=%h", act, exp_vec); end
            if (exp_on) begin
                total++;
                if (seg_l !== ~8'h06) begin bad++; $display("FAIL freeze_hold act=%h req=%h", seg_l, ~8'h06); end
            end
        end
        load = 1'b1;
        for (int i = 0; i < 2 * SD; i++) begin
            if (i == 6) load = 1'b0;
            tick(); total++;
            if (act !== exp_vec) begin bad++; $display("FAIL load_model act=%h req=%h", act, exp_vec); end
            if (i >= 4 && exp_on) begin
                total++;
                if (seg_l !== ~8'h5B) begin bad++; $display("FAIL load_value act=%h req=%h", seg_l, ~8'h5B); end
            end
        end
        freeze = 1'b0; number = 16'h3333;
        do begin
            tick(); total++;
            if (act !== exp_vec) begin bad++; $display("FAIL unfreeze_sync act=%h req=%h", act, exp_vec); end
        end while (kk % FRM != 0);
        repeat (FRM) begin
            tick(); total++;
            if (exp_on && seg_l !== ~8'h4F) begin bad++; $display("FAIL unfreeze_value act=%h req=%h", seg_l, ~8'h4F); end
        end
    endtask

    task automatic test_midframe();
        number = 16'h4444; freeze = 1'b0;
        do begin
            tick(); total++;
            if (act !== exp_vec) begin bad++; $display("FAIL mid_sync act=%h req=%h", act, exp_vec); end
        end while (kk % FRM != 0);
        repeat (15) tick();
        number = 16'h5555;
        do begin
            tick(); total++;
            if (act !== exp_vec) begin bad++; $display("FAIL mid_model act=%h req=%h", act, exp_vec); end
            if (exp_on) begin
                total++;
                if (seg_l !== ~8'h66) begin bad++; $display("FAIL mid_old act=%h req=%h", seg_l, ~8'h66); end
            end
        end while (kk % FRM != 0);
        repeat (FRM) begin
            tick(); total++;
            if (exp_on && seg_l !== ~8'h6D) begin bad++; $display("FAIL mid_new act=%h req=%h", seg_l, ~8'h6D); end
        end
    endtask

    task automatic test_random();
        repeat (800) begin
            if ($urandom_range(7) == 0) number = 16'($urandom);
            if ($urandom_range(7) == 0) dot = 4'($urandom);
            if ($urandom_range(15) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(15) == 0) freeze = ~freeze;
            if ($urandom_range(5) == 0) load = ~load;
            if ($urandom_range(3) == 0) number = number & 16'h00FF;
            tick(); total++;
            if (act !== exp_vec) begin bad++; $display("FAIL random k=%0d act=%h req=%h", kk, act, exp_vec); end
        end
        load = 1'b0; freeze = 1'b0; blank_lz = 1'b0;
    endtask

    task automatic test_polarity_reset();
        number = 16'h0008; dot = 4'h0;
        repeat (6) tick();
        do begin
            tick(); total++;
            if (act !== exp_vec) begin bad++; $display("FAIL pol_sync act=%h req=%h", act, exp_vec); end
        end while (kk % FRM != 0);
        repeat (BC + 1) tick();
        total++;
        if ({sel_h, seg_h} !== {4'b0001, 8'h7F}) begin
            bad++; $display("FAIL pol_high act=%b/%h req=0001/7f", sel_h, seg_h);
        end
        total++;
        if ({sel_l, seg_l} !== {4'b1110, 8'h80}) begin
            bad++; $display("FAIL pol_low act=%b/%h req=1110/80", sel_l, seg_l);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (act !== RST_VEC) begin bad++; $display("FAIL async_reset act=%h req=%h", act, RST_VEC); end
        tick(); total++;
        if (act !== RST_VEC) begin bad++; $display("FAIL reset_hold2 act=%h req=%h", act, RST_VEC); end
        rst_n = 1'b1;
        repeat (BC + 1) begin
            tick(); total++;
            if (act !== exp_vec) begin bad++; $display("FAIL restart act=%h req=%h", act, exp_vec); end
        end
        total++;
        if (sel_h !== 4'b0001) begin bad++; $display("FAIL restart_digit0 act=%b req=0001", sel_h); end
    endtask

    initial begin
        @(negedge clk_1m);
        test_reset();
        test_digits();
        test_lz();
        test_freeze();
        test_midframe();
        test_random();
        test_polarity_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
